// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame/synchronizer defaults, link state and clock mode.
// Used by both the SPI slave and the SPI master.
package spi_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Single-bit flop synchronizer of configurable depth, cleared by async active-low reset.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic global_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] pipe;

    always_ff @(posedge global_clk or negedge reset) begin
        if (!reset) begin
            pipe <= '0;
        end else begin
            pipe <= {pipe[STAGES-2:0], d};
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave (mode 0) oversampled on global_clk, with tx holding buffer and rx handshake.
// Define SPI_SLAVE_OVERRUN_EN to build the sticky rx_ovr overrun detector.
//
// state  | meaning
// IDLE   | ss high: miso held 0, sclk ignored
// ACTIVE | ss low: shifting a frame, back-to-back frames allowed
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              global_clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_ovr
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_s, ss_s, mosi_s;
    logic sclk_d, ss_d, mosi_d;
    logic lead, trail, sample_edge, shift_edge;
    logic sample_q, shift_q;
    logic ss_fall, ss_rise;

    spi_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_buf;
    logic [DATA_W-1:0] load_word;
    logic              skip_shift;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.global_clk(global_clk), .reset(reset), .d(sclk), .q(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss   (.global_clk(global_clk), .reset(reset), .d(ss),   .q(ss_s));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.global_clk(global_clk), .reset(reset), .d(mosi), .q(mosi_s));

    assign lead        = (sclk_s ^ sclk_d) & (sclk_s ^ CPOL);
    assign trail       = (sclk_s ^ sclk_d) & ~(sclk_s ^ CPOL);
    assign sample_edge = CPHA ? trail : lead;
    assign shift_edge  = CPHA ? lead : trail;
    assign ss_fall     = ss_d & ~ss_s;
    assign ss_rise     = ~ss_d & ss_s;
    assign rx_next     = {rx_shift, mosi_d};
    assign load_word   = tx_ready ? '0 : tx_buf;

    always_ff @(posedge global_clk or negedge reset) begin
        if (!reset) begin
            sclk_d     <= 1'b0;
            ss_d       <= 1'b0;
            mosi_d     <= 1'b0;
            sample_q   <= 1'b0;
            shift_q    <= 1'b0;
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_buf     <= '0;
            skip_shift <= 1'b0;
            tx_ready   <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            miso       <= 1'b0;
        end else begin
            sclk_d   <= sclk_s;
            ss_d     <= ss_s;
            mosi_d   <= mosi_s;
            // Edge pulses and data are re-registered together so they stay aligned.
            sample_q <= sample_edge;
            shift_q  <= shift_edge;

            if (tx_load && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end
            if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (ss_fall) begin
                        state      <= ACTIVE;
                        bit_cnt    <= '0;
                        tx_shift   <= load_word;
                        miso       <= load_word[DATA_W-1];
                        skip_shift <= 1'b0;
                        if (!tx_ready) tx_ready <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state      <= IDLE;
                        bit_cnt    <= '0;
                        tx_shift   <= '0;
                        miso       <= 1'b0;
                        skip_shift <= 1'b0;
                    end else if (sample_q) begin
                        rx_shift <= rx_next[DATA_W-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt    <= '0;
                            rx_data    <= rx_next;
                            rx_valid   <= 1'b1;
                            tx_shift   <= load_word;
                            miso       <= load_word[DATA_W-1];
                            // The trailing edge of the last bit must not shift out the new MSB.
                            skip_shift <= 1'b1;
                            if (!tx_ready) tx_ready <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (shift_q) begin
                        if (skip_shift) begin
                            skip_shift <= 1'b0;
                        end else begin
                            tx_shift <= tx_shift << 1;
                            miso     <= tx_shift[DATA_W-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    always_ff @(posedge global_clk or negedge reset) begin
        if (!reset) begin
            rx_ovr <= 1'b0;
        end else if (state == ACTIVE && !ss_rise && sample_q && bit_cnt == LAST_BIT
                     && rx_valid && !rx_ack) begin
            rx_ovr <= 1'b1;
        end else if (rx_ack) begin
            rx_ovr <= 1'b0;
        end
    end
`else
    assign rx_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: mode-0 frames driven from global_clk negedges, 8 clocks per sclk period.
module tb_spi_slave;

    logic       global_clk = 1'b0;
    logic       reset      = 1'b0;
    logic       sclk       = 1'b0;
    logic       ss         = 1'b1;
    logic       mosi       = 1'b0;
    logic [7:0] tx_data    = 8'h00;
    logic       tx_load    = 1'b0;
    logic       rx_ack     = 1'b0;
    logic       miso;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ovr;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] got;

`ifdef SPI_SLAVE_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .global_clk(global_clk),
        .reset     (reset),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .rx_ovr    (rx_ovr)
    );

    always #5 global_clk = ~global_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge global_clk);
    endtask

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    task automatic ss_down();
        ss = 1'b0;
        tick(4);
    endtask

    task automatic ss_up();
        tick(4);
        ss = 1'b1;
        tick(4);
    endtask

    // Master side of a frame: miso captured just before each rising sclk edge.
    task automatic frame(input logic [7:0] w, input int nbits, input bit lat, output logic [7:0] m);
        m = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = w[i];
            tick(4);
            m[i] = miso;
            sclk = 1'b1;
            if (lat && i == 0) begin
                tick(3);
                check("latency_before", 32'(rx_valid), 0);
                tick(1);
                check("latency_at", 32'(rx_valid), 1);
            end else begin
                tick(4);
            end
            sclk = 1'b0;
        end
    endtask

    initial begin
        tick(3);
        check("rst_miso", 32'(miso), 0);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_rx_ovr", 32'(rx_ovr), 0);
        reset = 1'b1;
        tick(2);

        // Basic frame: 0xA5 out, 0x3C in
        load(8'hA5);
        check("a5_tx_ready_full", 32'(tx_ready), 0);
        ss_down();
        check("a5_tx_ready_after_ss", 32'(tx_ready), 1);
        check("a5_miso_msb_on_entry", 32'(miso), 1);
        frame(8'h3C, 8, 1'b1, got);
        check("a5_miso_word", 32'(got), 32'hA5);
        ss_up();
        check("a5_rx_data", 32'(rx_data), 32'h3C);
        check("a5_rx_valid", 32'(rx_valid), 1);
        check("idle_miso", 32'(miso), 0);
        ack();
        check("a5_ack_clears_valid", 32'(rx_valid), 0);

        // Back-to-back frames without ack, empty holding buffer
        ss_down();
        frame(8'h01, 8, 1'b0, got);
        check("b2b_miso_empty_1", 32'(got), 0);
        frame(8'hFE, 8, 1'b0, got);
        check("b2b_miso_empty_2", 32'(got), 0);
        ss_up();
        check("b2b_rx_data", 32'(rx_data), 32'hFE);
        check("b2b_rx_valid", 32'(rx_valid), 1);
        check("b2b_rx_ovr", 32'(rx_ovr), 32'(OVR_EXP));
        ack();
        check("b2b_ack_valid", 32'(rx_valid), 0);
        check("b2b_ack_ovr", 32'(rx_ovr), 0);

        // Aborted partial frame then a full one
        ss_down();
        frame(8'hFF, 5, 1'b0, got);
        ss_up();
        check("abort_no_valid", 32'(rx_valid), 0);
        ss_down();
        frame(8'h81, 8, 1'b0, got);
        ss_up();
        check("after_abort_rx_data", 32'(rx_data), 32'h81);
        check("after_abort_rx_valid", 32'(rx_valid), 1);
        check("after_abort_ovr", 32'(rx_ovr), 0);
        ack();

        // Second load while buffer full is ignored
        load(8'h11);
        load(8'h22);
        check("dbl_load_tx_ready", 32'(tx_ready), 0);
        ss_down();
        check("dbl_load_ready_after_ss", 32'(tx_ready), 1);
        frame(8'h33, 8, 1'b0, got);
        check("dbl_load_miso_first", 32'(got), 32'h11);
        frame(8'hC3, 8, 1'b0, got);
        check("dbl_load_miso_second", 32'(got), 0);
        ss_up();
        check("dbl_load_rx_data", 32'(rx_data), 32'hC3);
        ack();

        // Reset mid-frame
        ss_down();
        load(8'h99);
        check("mid_rst_buffer_full", 32'(tx_ready), 0);
        frame(8'hF0, 4, 1'b0, got);
        reset = 1'b0;
        tick(2);
        check("mid_rst_miso", 32'(miso), 0);
        check("mid_rst_tx_ready", 32'(tx_ready), 1);
        check("mid_rst_rx_valid", 32'(rx_valid), 0);
        check("mid_rst_rx_data", 32'(rx_data), 0);
        check("mid_rst_rx_ovr", 32'(rx_ovr), 0);
        reset = 1'b1;
        tick(2);
        frame(8'hFF, 8, 1'b0, got);
        check("post_rst_no_frame_valid", 32'(rx_valid), 0);
        check("post_rst_no_frame_miso", 32'(got), 0);
        ss_up();
        ss_down();
        frame(8'h5A, 8, 1'b0, got);
        ss_up();
        check("post_rst_rx_data", 32'(rx_data), 32'h5A);
        check("post_rst_rx_valid", 32'(rx_valid), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
